// File: rtl/clk_en_sched.sv
// clk_en_sched: four-channel programmable clock-enable scheduler.
//
// Each channel emits a registered one-cycle tick every div[i] cycles of clk.
// Divisors can be changed at run time through a valid/ready config port. A
// change is held pending until the target channel reaches a period boundary,
// so a period in progress is never cut short.
//
// Handshake: a config request transfers on a rising edge where
// cfg_valid && cfg_ready. cfg_ready is high only in IDLE. A zero divisor is
// rejected with a one-cycle cfg_err pulse. An accepted request produces a
// one-cycle cfg_done pulse in the cycle after the new divisor is written.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous, active-high reset
//   en[3:0]    per-channel enable; low holds the channel counter at zero
//   sync       restarts every channel counter (phase align)
//   cfg_valid  config request valid
//   cfg_ready  scheduler can accept a request (decoded from state)
//   cfg_ch     target channel of the request
//   cfg_div    new divisor for the target channel (0 is illegal)
//   cfg_done   one-cycle pulse once the new divisor is in effect
//   cfg_err    one-cycle pulse when a request is rejected
//   busy       a request is pending (decoded from state)
//   tick[3:0]  registered per-channel enable pulses

module clk_en_sched #(
    parameter int DW   = 16,
    parameter int DIV0 = 4,
    parameter int DIV1 = 2,
    parameter int DIV2 = 1,
    parameter int DIV3 = 868
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    en,
    input  logic          sync,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [1:0]    cfg_ch,
    input  logic [DW-1:0] cfg_div,
    output logic          cfg_done,
    output logic          cfg_err,
    output logic          busy,
    output logic [3:0]    tick
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [DW-1:0] DIV_RST [4] = '{DW'(DIV0), DW'(DIV1), DW'(DIV2), DW'(DIV3)};

    state_t        state_q, state_d;
    logic [DW-1:0] div_q [4];
    logic [DW-1:0] div_d [4];
    logic [DW-1:0] cnt_q [4];
    logic [DW-1:0] cnt_d [4];
    logic [3:0]    tick_q, tick_d;
    logic [1:0]    pch_q, pch_d;
    logic [DW-1:0] pdiv_q, pdiv_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [3:0]    term;
    logic          apply;

    // Terminal count: last cycle of the current period for each channel.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            term[i] = (cnt_q[i] == (div_q[i] - DW'(1)));
        end
    end

    always_comb begin
        state_d = state_q;
        pch_d   = pch_q;
        pdiv_d  = pdiv_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        apply   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    if (cfg_div == '0) begin
                        err_d = 1'b1;
                    end else begin
                        pch_d   = cfg_ch;
                        pdiv_d  = cfg_div;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Any of these restarts the target's period, so the new
                // divisor can be swapped in without shortening a tick.
                if (term[pch_q] || !en[pch_q] || sync) begin
                    apply   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        for (int i = 0; i < 4; i++) begin
            div_d[i] = div_q[i];
            if (!en[i] || sync) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b0;
            end else begin
                tick_d[i] = term[i];
                cnt_d[i]  = term[i] ? '0 : cnt_q[i] + DW'(1);
            end
            // The old terminal tick (if any) is kept; only div/cnt change.
            if (apply && (pch_q == 2'(i))) begin
                div_d[i] = pdiv_q;
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pch_q   <= '0;
            pdiv_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tick_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                div_q[i] <= DIV_RST[i];
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pch_q   <= pch_d;
            pdiv_q  <= pdiv_d;
            done_q  <= done_d;
            err_q   <= err_d;
            tick_q  <= tick_d;
            for (int i = 0; i < 4; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign cfg_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign tick      = tick_q;

endmodule

// File: doc/clk_en_sched.md
Name: clk_en_sched

Overview:
- Programmable clock-enable scheduler on the single 100 MHz system clock.
- Four channels, each emitting a one-cycle tick every N cycles (N = channel divisor), for VGA pixel, UART baud and peripheral timing.
- Replaces free-running toggled clocks with enables.
- Divisors reconfigure at run time through a valid/ready port; changes apply only at the target channel's period boundary, so no tick is ever shortened.

Parameters:
- DW, 16, divisor width.
- DIV0, 4, channel 0 reset divisor (25 MHz pixel enable).
- DIV1, 2, channel 1 reset divisor (50 MHz enable).
- DIV2, 1, channel 2 reset divisor (every cycle).
- DIV3, 868, channel 3 reset divisor (115200 baud at 100 MHz).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  4  per-channel enable.
- sync  in  1  phase-align pulse, restarts all channel counters.
- cfg_valid  in  1  config request valid.
- cfg_ready  out  1  scheduler can accept config.
- cfg_ch  in  2  target channel.
- cfg_div  in  DW  new divisor (0 illegal).
- cfg_done  out  1  one-cycle pulse when the new divisor takes effect.
- cfg_err  out  1  one-cycle pulse when a request is rejected.
- busy  out  1  config pending (state != IDLE).
- tick  out  4  registered per-channel enable pulses.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: div[i] = DIVi, cnt[i] = 0, tick = 0, cfg_done = 0, cfg_err = 0, busy = 0, state = IDLE, cfg_ready = 1.
- Per channel, each edge:
  - en[i] = 0: cnt[i] <= 0, tick[i] <= 0.
  - Otherwise: tick[i] <= (cnt[i] == div[i]-1); cnt[i] <= terminal ? 0 : cnt[i]+1.
  - First tick is high after the div-th edge following en rise or reset release; repeats every div edges.
  - div = 1 gives tick high every cycle.
- sync = 1: all cnt <= 0 and all tick <= 0 that edge; next tick at div edges later. sync overrides terminal detection.
- Config FSM:
  - IDLE (cfg_ready = 1): on cfg_valid with cfg_div == 0, pulse cfg_err next cycle, stay IDLE, no state change. With cfg_div != 0, latch ch/div into pending regs, go WAIT.
  - WAIT (cfg_ready = 0, busy = 1): boundary = target cnt at terminal, or target en = 0, or sync = 1. At boundary, that same edge: div[ch] <= pending, cnt[ch] <= 0; go DONE. The tick from the old terminal still fires. The next tick comes new_div edges after it.
  - DONE (busy = 1, cfg_ready = 0): cfg_done = 1 for this one cycle, then IDLE. Back-to-back requests are therefore spaced by at least 3 cycles.
- Untargeted channels are never disturbed by config.
- Writing the same divisor is legal and still passes through WAIT/DONE.
- Reset asserted in WAIT/DONE: pending request is discarded, divisors return to parameter defaults, no cfg_done.
- All outputs are registered except cfg_ready and busy, which decode from the state register.
- No arithmetic overflow: cnt is DW bits wide, and cnt < div <= 2^DW-1 always holds.

Test Plan:
- Reset release, en = 4'b1111, run 1800 cycles → tick0 period 4, tick1 period 2, tick2 high every cycle, tick3 period 868; first tick0 after edge 4.
- Config ch0 = 10 issued when cnt0 = 1 → cfg_ready drops; tick0 fires at its normal old-period edge; apply in that edge; cfg_done one cycle later; subsequent tick0 spacing 10; ticks 1–3 unchanged.
- cfg_div = 0 on ch3 → cfg_err pulse 1 cycle; busy stays 0; tick3 period remains 868.
- en[1] = 0 during WAIT for ch1 = 7 → immediate apply; cfg_done next cycle; after en[1] = 1, first tick1 after 7 edges.
- sync pulse mid-run with a ch3 request pending → all counters zero; ch3 applied the same edge; all channels next tick at their div from the sync edge.
- rst asserted while in WAIT → state IDLE, div0 back to 4; no cfg_done; tick0 resumes period 4.
